hazard_ctrl_multi: RTL and testbench
====================================

# hazard_ctrl_multi

Parametrised pipeline hazard/forwarding controller for the in-order RISC-V core: generalises the fixed five-stage stall/nop/forwarding logic to a configurable number of ID source operands and forwarding producer stages, a configurable load-to-use latency and a multi-cycle branch flush. Sits beside the pipeline registers: it reads destination/source register tags and memory handshakes, then drives per-stage stall/nop controls plus registered per-operand forwarding selects. Saturating performance counters for stall, bubble and flush cycles are included.

## Interface
- `NUM_SRC`, 2: source operands checked in ID.
- `FWD_DEPTH`, 3: producer stages after ID (1=EX, 2=MEM, 3=WB, …).
- `LOAD_LAT`, 2: a load's data is forwardable once it reaches producer stage ≥ LOAD_LAT.
- `FLUSH_CYCLES`, 1: cycles of IF/ID/EX squash per taken branch (≥1).
- `REGW`, 5: register tag width.
- `CNT_W`, 16: performance counter width.
- `SELW`, $clog2(FWD_DEPTH+1): forwarding select width (derived).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs`  in  NUM_SRC*REGW  ID source tags; operand s at [s*REGW +: REGW].
- `id_rs_vld`  in  NUM_SRC  operand s is actually read.
- `prod_rd`  in  FWD_DEPTH*REGW  destination tag of producer stage k (k-1 slice).
- `prod_we`  in  FWD_DEPTH  producer k writes a register.
- `prod_load`  in  FWD_DEPTH  producer k is a load (opcode 0000011).
- `branch_taken`  in  1  branch/jump resolved taken this cycle.
- `iready_n`, `dready_n`, `dbusy`  in  1 each  cache handshakes.
- `mem_rw`  in  2  MEM-stage access type; [1]=read, [0]=write.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`, `stall_wb`  out  1 each  hold stage register.
- `nop_if`, `nop_id`, `nop_ex`, `nop_mem`, `nop_wb`  out  1 each  load bubble into stage register.
- `fwd_sel`  out  NUM_SRC*SELW  registered select per operand; 0 = register file, k = producer k.
- `state`  out  2  0 RUN, 1 LDSTALL, 2 MEMSTALL, 3 FLUSH.
- `cnt_stall`, `cnt_bubble`, `cnt_flush`  out  CNT_W each  saturating counters.

## Operation
- `mem_stall` = iready_n | (dready_n & mem_rw[1]) | (dbusy & mem_rw[0]).
- Match(s,k) = id_rs_vld[s] & prod_we[k] & prod_rd[k]≠0 & prod_rd[k]==rs[s]. Nearest(s) = the smallest k with a match, else 0.
- `ld_haz` = there is an s with Nearest(s)=k≠0, prod_load[k]=1 and k < LOAD_LAT. A farther, older match is ignored when a nearer one exists.
- Per-cycle decision, in priority order:
  1. `mem_stall`: all stall_* = 1, all nop_* = 0. next state MEMSTALL. The flush countdown is frozen.
  2. `branch_taken`, or state FLUSH with remaining count > 0: nop_if, nop_id and nop_ex = 1, all stalls = 0. On branch_taken the counter reloads to FLUSH_CYCLES-1. next state FLUSH while the remaining count is > 0, else RUN. `ld_haz` is ignored.
  3. `ld_haz`: stall_if = stall_id = 1, nop_ex = 1. next state LDSTALL.
  4. Otherwise every output is 0. next state RUN.
- From MEMSTALL the block returns to the state implied by the rules above once `mem_stall` drops. A FLUSH interrupted by a memory stall resumes its remaining count.
- `fwd_sel[s]` updates only in rule-4 cycles and rule-2 cycles, to Nearest(s) (to 0 under rule 2). It holds otherwise. The datapath applies the value when the consumer is in EX, reading producer stage Nearest+1.
- Counters increment by 1 and saturate at 2^CNT_W-1:
  - `cnt_stall` counts rule-1 cycles.
  - `cnt_bubble` counts rule-3 cycles.
  - `cnt_flush` counts rule-2 cycles.

## Timing
- Stall/nop outputs are combinational from the inputs, the state and the flush counter. They are valid in the same cycle as the cause.
- `state`, `fwd_sel` and the counters are registered: they reflect the decision one cycle after it is made.
- Load-use bubbles last LOAD_LAT-k cycles, because the load advances while ID is held. With the defaults, a load in EX with a dependent instruction in ID costs 1 bubble.
- Reset: all stall_*, nop_* and fwd_sel = 0, state = RUN, counters = 0, flush count = 0. Reset asserted mid-flush or mid-stall wins the same edge.
- `branch_taken` coincident with `ld_haz`: flush wins and no bubble is counted. `branch_taken` coincident with `mem_stall`: the stall wins. The branch must be re-presented by the EX stage, which is being held.

## Test plan
- Reset: assert rst for 2 cycles mid-FLUSH → every output 0 and state 0 on the next edge.
- Load-use: prod_rd[0]=5, prod_we[0]=1, prod_load[0]=1, id_rs0=5 → stall_id=1 and nop_ex=1 for 1 cycle, cnt_bubble=1. Next cycle (producer now at k=2): fwd_sel0=2 registered.
- Nearest wins: rs1=7 matches k=1 (ALU op) and k=2 (load) → no stall, fwd_sel1=1. Same tags with rd=0 → fwd_sel1=0.
- FLUSH_CYCLES=3: branch_taken for 1 cycle → nop_if/id/ex high for 3 consecutive cycles, cnt_flush=3. A second branch in cycle 2 extends the window to cycle 4.
- Memory stall: dready_n=1 with mem_rw=2'b10 for 4 cycles during a flush → all stalls high, no nops, cnt_stall=4, remaining flush cycles resume afterwards. dready_n=1 with mem_rw=2'b01 → no stall.
- Saturation: CNT_W=2 with 6 stall cycles → cnt_stall holds 3.

Source files
------------

// File: rtl/hazard_ctrl_multi.sv
// hazard_ctrl_multi: parametrised stall / bubble / flush / forwarding controller
// for the in-order pipeline. Stall and nop controls are combinational. State,
// forwarding selects and the performance counters are registered.
module hazard_ctrl_multi #(
  parameter int NUM_SRC      = 2,
  parameter int FWD_DEPTH    = 3,
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int REGW         = 5,
  parameter int CNT_W        = 16,
  parameter int SELW         = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REGW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_vld,
  input  logic [FWD_DEPTH*REGW-1:0] prod_rd,
  input  logic [FWD_DEPTH-1:0]      prod_we,
  input  logic [FWD_DEPTH-1:0]      prod_load,
  input  logic                      branch_taken,
  input  logic                      iready_n,
  input  logic                      dready_n,
  input  logic                      dbusy,
  input  logic [1:0]                mem_rw,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      stall_mem,
  output logic                      stall_wb,
  output logic                      nop_if,
  output logic                      nop_id,
  output logic                      nop_ex,
  output logic                      nop_mem,
  output logic                      nop_wb,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic [1:0]                state,
  output logic [CNT_W-1:0]          cnt_stall,
  output logic [CNT_W-1:0]          cnt_bubble,
  output logic [CNT_W-1:0]          cnt_flush
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LDSTALL  = 2'd1;
  localparam logic [1:0] ST_MEMSTALL = 2'd2;
  localparam logic [1:0] ST_FLUSH    = 2'd3;

  // The countdown only ever holds FLUSH_CYCLES-1 down to 0.
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_bubble_q, cnt_bubble_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

  logic [NUM_SRC-1:0] src_haz;
  logic               mem_stall, ld_haz, flush_act;
  logic               rule_stall, rule_flush, rule_bubble, rule_run;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [SELW-1:0] near;
      logic            haz;
      logic [SELW-1:0] sel_q, sel_d;

      // Nearest matching producer for this operand; a not-yet-ready load there is a hazard
      always_comb begin
        near = '0;
        haz  = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
          if (id_rs_vld[gi] && prod_we[k] &&
              (prod_rd[k*REGW +: REGW] != '0) &&
              (prod_rd[k*REGW +: REGW] == id_rs[gi*REGW +: REGW])) begin
            near = SELW'(k + 1);
            haz  = prod_load[k] && ((k + 1) < LOAD_LAT);
          end
        end
      end

      // Select follows the nearest producer when the pipe advances, clears on a flush
      always_comb begin
        sel_d = sel_q;
        if (rule_run) begin
          sel_d = near;
        end else if (rule_flush) begin
          sel_d = '0;
        end
      end

      // Registered forwarding select for this operand
      always_ff @(posedge clk) begin
        if (rst) begin
          sel_q <= '0;
        end else begin
          sel_q <= sel_d;
        end
      end

      assign src_haz[gi]                 = haz;
      assign fwd_sel[gi*SELW +: SELW]    = sel_q;
    end
  endgenerate

  // Prioritised per-cycle decision: memory stall, flush, load-use bubble, run
  always_comb begin
    mem_stall   = iready_n | (dready_n & mem_rw[1]) | (dbusy & mem_rw[0]);
    ld_haz      = |src_haz;
    flush_act   = branch_taken | (flush_cnt_q != '0);
    state_d     = ST_RUN;
    flush_cnt_d = flush_cnt_q;
    rule_stall  = 1'b0;
    rule_flush  = 1'b0;
    rule_bubble = 1'b0;
    rule_run    = 1'b0;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    stall_wb    = 1'b0;
    nop_if      = 1'b0;
    nop_id      = 1'b0;
    nop_ex      = 1'b0;
    nop_mem     = 1'b0;
    nop_wb      = 1'b0;
    if (mem_stall) begin
      rule_stall = 1'b1;
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
      stall_mem  = 1'b1;
      stall_wb   = 1'b1;
      state_d    = ST_MEMSTALL;
    end else if (flush_act) begin
      rule_flush  = 1'b1;
      nop_if      = 1'b1;
      nop_id      = 1'b1;
      nop_ex      = 1'b1;
      flush_cnt_d = branch_taken ? FLUSH_RELOAD : (flush_cnt_q - FCW'(1));
      state_d     = (flush_cnt_d != '0) ? ST_FLUSH : ST_RUN;
    end else if (ld_haz) begin
      rule_bubble = 1'b1;
      stall_if    = 1'b1;
      stall_id    = 1'b1;
      nop_ex      = 1'b1;
      state_d     = ST_LDSTALL;
    end else begin
      rule_run = 1'b1;
    end
    // Reset silences every control in the same cycle it is asserted
    if (rst) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      stall_wb  = 1'b0;
      nop_if    = 1'b0;
      nop_id    = 1'b0;
      nop_ex    = 1'b0;
      nop_mem   = 1'b0;
      nop_wb    = 1'b0;
    end
  end

  // Saturating increments of the performance counters
  always_comb begin
    cnt_stall_d  = (rule_stall  && (cnt_stall_q  != '1)) ? cnt_stall_q  + CNT_W'(1) : cnt_stall_q;
    cnt_bubble_d = (rule_bubble && (cnt_bubble_q != '1)) ? cnt_bubble_q + CNT_W'(1) : cnt_bubble_q;
    cnt_flush_d  = (rule_flush  && (cnt_flush_q  != '1)) ? cnt_flush_q  + CNT_W'(1) : cnt_flush_q;
  end

  // State, flush countdown and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_cnt_q  <= '0;
      cnt_stall_q  <= '0;
      cnt_bubble_q <= '0;
      cnt_flush_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      cnt_stall_q  <= cnt_stall_d;
      cnt_bubble_q <= cnt_bubble_d;
      cnt_flush_q  <= cnt_flush_d;
    end
  end

  assign state      = state_q;
  assign cnt_stall  = cnt_stall_q;
  assign cnt_bubble = cnt_bubble_q;
  assign cnt_flush  = cnt_flush_q;

endmodule

// File: tb/tb_hazard_ctrl_multi.sv
// Bench for hazard_ctrl_multi: two instances (16-bit and 2-bit counters, both
// with a 3-cycle flush) share directed stimulus; a rule-level model checks
// every cycle and literal checks pin the headline scenarios.
module tb_hazard_ctrl_multi;

  localparam int NS = 2;
  localparam int FD = 3;
  localparam int LL = 2;
  localparam int FC = 3;
  localparam int RW = 5;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*RW-1:0] id_rs;
  logic [NS-1:0]   id_rs_vld;
  logic [FD*RW-1:0] prod_rd;
  logic [FD-1:0]   prod_we, prod_load;
  logic            branch_taken, iready_n, dready_n, dbusy;
  logic [1:0]      mem_rw;

  logic a_sif, a_sid, a_sex, a_smem, a_swb, a_nif, a_nid, a_nex, a_nmem, a_nwb;
  logic b_sif, b_sid, b_sex, b_smem, b_swb, b_nif, b_nid, b_nex, b_nmem, b_nwb;
  logic [NS*SW-1:0] a_fwd, b_fwd;
  logic [1:0]       a_state, b_state;
  logic [15:0]      a_cst, a_cbub, a_cfl;
  logic [1:0]       b_cst, b_cbub, b_cfl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_multi #(.NUM_SRC(NS), .FWD_DEPTH(FD), .LOAD_LAT(LL), .FLUSH_CYCLES(FC),
                      .REGW(RW), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_vld(id_rs_vld), .prod_rd(prod_rd),
    .prod_we(prod_we), .prod_load(prod_load), .branch_taken(branch_taken),
    .iready_n(iready_n), .dready_n(dready_n), .dbusy(dbusy), .mem_rw(mem_rw),
    .stall_if(a_sif), .stall_id(a_sid), .stall_ex(a_sex), .stall_mem(a_smem), .stall_wb(a_swb),
    .nop_if(a_nif), .nop_id(a_nid), .nop_ex(a_nex), .nop_mem(a_nmem), .nop_wb(a_nwb),
    .fwd_sel(a_fwd), .state(a_state), .cnt_stall(a_cst), .cnt_bubble(a_cbub), .cnt_flush(a_cfl));

  hazard_ctrl_multi #(.NUM_SRC(NS), .FWD_DEPTH(FD), .LOAD_LAT(LL), .FLUSH_CYCLES(FC),
                      .REGW(RW), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_vld(id_rs_vld), .prod_rd(prod_rd),
    .prod_we(prod_we), .prod_load(prod_load), .branch_taken(branch_taken),
    .iready_n(iready_n), .dready_n(dready_n), .dbusy(dbusy), .mem_rw(mem_rw),
    .stall_if(b_sif), .stall_id(b_sid), .stall_ex(b_sex), .stall_mem(b_smem), .stall_wb(b_swb),
    .nop_if(b_nif), .nop_id(b_nid), .nop_ex(b_nex), .nop_mem(b_nmem), .nop_wb(b_nwb),
    .fwd_sel(b_fwd), .state(b_state), .cnt_stall(b_cst), .cnt_bubble(b_cbub), .cnt_flush(b_cfl));

  wire [9:0] a_ctl = {a_sif, a_sid, a_sex, a_smem, a_swb, a_nif, a_nid, a_nex, a_nmem, a_nwb};
  wire [9:0] b_ctl = {b_sif, b_sid, b_sex, b_smem, b_swb, b_nif, b_nid, b_nex, b_nmem, b_nwb};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- rule-level reference model ----------------
  int m_state = 0, m_rem = 0, m_cst = 0, m_cbub = 0, m_cfl = 0;
  int m_fwd [NS];
  bit m_valid = 1'b0;

  function automatic int nearest(input int s);
    for (int k = 0; k < FD; k++) begin
      if (id_rs_vld[s] && prod_we[k] && prod_rd[k*RW +: RW] != 0 &&
          prod_rd[k*RW +: RW] == id_rs[s*RW +: RW])
        return k + 1;
    end
    return 0;
  endfunction

  function automatic int decide();
    int n;
    if (iready_n || (dready_n && mem_rw[1]) || (dbusy && mem_rw[0])) return 1;
    if (branch_taken || m_rem > 0) return 2;
    for (int s = 0; s < NS; s++) begin
      n = nearest(s);
      if (n != 0 && prod_load[n-1] && n < LL) return 3;
    end
    return 4;
  endfunction

  function automatic int sat3(input int c);
    return (c > 3) ? 3 : c;
  endfunction

  initial begin
    int rule;
    logic [9:0] exp_ctl;
    for (int s = 0; s < NS; s++) m_fwd[s] = 0;
    forever begin
      @(negedge clk);
      rule = decide();
      case (rule)
        1:       exp_ctl = 10'b11111_00000;
        2:       exp_ctl = 10'b00000_11100;
        3:       exp_ctl = 10'b11000_00100;
        default: exp_ctl = 10'b00000_00000;
      endcase
      if (rst) exp_ctl = '0;
      if (m_valid) begin
        chk("model_ctl_a", a_ctl, exp_ctl);
        chk("model_ctl_b", b_ctl, exp_ctl);
        chk("model_state", a_state, m_state);
        chk("model_fwd", a_fwd, m_fwd[0] + 4 * m_fwd[1]);
        chk("model_cnt_stall_a", a_cst, m_cst);
        chk("model_cnt_bubble_a", a_cbub, m_cbub);
        chk("model_cnt_flush_a", a_cfl, m_cfl);
        chk("model_cnt_stall_b", b_cst, sat3(m_cst));
        chk("model_cnt_bubble_b", b_cbub, sat3(m_cbub));
        chk("model_cnt_flush_b", b_cfl, sat3(m_cfl));
      end
      @(posedge clk);
      if (rst) begin
        m_state = 0; m_rem = 0; m_cst = 0; m_cbub = 0; m_cfl = 0;
        for (int s = 0; s < NS; s++) m_fwd[s] = 0;
        m_valid = 1'b1;
      end else begin
        case (rule)
          1: begin m_state = 2; m_cst++; end
          2: begin
            m_rem   = branch_taken ? FC - 1 : m_rem - 1;
            m_state = (m_rem > 0) ? 3 : 0;
            m_cfl++;
            for (int s = 0; s < NS; s++) m_fwd[s] = 0;
          end
          3: begin m_state = 1; m_cbub++; end
          default: begin
            m_state = 0;
            for (int s = 0; s < NS; s++) m_fwd[s] = nearest(s);
          end
        endcase
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rs_vld = '0; prod_rd = '0; prod_we = '0; prod_load = '0;
    branch_taken = 1'b0; iready_n = 1'b0; dready_n = 1'b0; dbusy = 1'b0; mem_rw = 2'b00;
  endtask

  task automatic set_prod(input int k, input int rd, input bit we, input bit ld);
    prod_rd[k*RW +: RW] = RW'(rd);
    prod_we[k]          = we;
    prod_load[k]        = ld;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    tick(); #1;
    $display("reset: state=%0d cnt_flush=%0d", a_state, a_cfl);
    chk("reset_state", a_state, 0);
    chk("reset_cnt_stall", a_cst, 0);
    chk("reset_fwd", a_fwd, 0);

    // single branch, three flush cycles
    branch_taken = 1'b1; #1;
    chk("flush_c1_nop_if", a_nif, 1);
    tick(); branch_taken = 1'b0; #1;
    chk("flush_c2_nop_ex", a_nex, 1);
    chk("flush_c2_state", a_state, 3);
    tick(); #1;
    chk("flush_c3_nop_id", a_nid, 1);
    tick(); #1;
    $display("flush: nop_if=%0d state=%0d cnt_flush=%0d", a_nif, a_state, a_cfl);
    chk("flush_end_nop_if", a_nif, 0);
    chk("flush_end_state", a_state, 0);
    chk("flush_cnt", a_cfl, 3);

    // reset arriving in the middle of a flush
    branch_taken = 1'b1; tick(); branch_taken = 1'b0;
    rst = 1'b1; #1;
    chk("rst_mid_flush_nop_if", a_nif, 0);
    tick(); tick(); rst = 1'b0; #1;
    $display("reset mid-flush: state=%0d cnt_flush=%0d nop_if=%0d", a_state, a_cfl, a_nif);
    chk("rst_mid_flush_state", a_state, 0);
    chk("rst_mid_flush_cnt", a_cfl, 0);
    chk("rst_mid_flush_nop_after", a_nif, 0);

    // second branch in cycle 2 extends the window to 4 cycles
    branch_taken = 1'b1; tick();
    tick(); branch_taken = 1'b0; #1;
    chk("flush2_c3_nop", a_nif, 1);
    tick(); #1;
    chk("flush2_c4_nop", a_nif, 1);
    tick(); #1;
    $display("double branch: nop_if=%0d cnt_flush=%0d", a_nif, a_cfl);
    chk("flush2_c5_nop", a_nif, 0);
    chk("flush2_cnt", a_cfl, 4);
    chk("flush2_cnt_b_sat", b_cfl, 3);

    // load in EX feeding operand 0 in ID
    id_rs[0 +: RW] = 5'd5; id_rs_vld[0] = 1'b1;
    set_prod(0, 5, 1, 1); #1;
    chk("lu_stall_id", a_sid, 1);
    chk("lu_nop_ex", a_nex, 1);
    chk("lu_nop_id", a_nid, 0);
    tick();
    set_prod(0, 0, 0, 0); set_prod(1, 5, 1, 1); #1;
    chk("lu_released", a_sid, 0);
    chk("lu_cnt_bubble", a_cbub, 1);
    chk("lu_state", a_state, 1);
    tick(); #1;
    $display("load-use: fwd_sel0=%0d cnt_bubble=%0d", a_fwd[1:0], a_cbub);
    chk("lu_fwd_sel0", a_fwd[1:0], 2);
    idle(); tick();

    // nearest producer wins over an older load
    id_rs[RW +: RW] = 5'd7; id_rs_vld[1] = 1'b1;
    set_prod(0, 7, 1, 0); set_prod(1, 7, 1, 1); #1;
    chk("near_no_stall", a_sid, 0);
    tick(); #1;
    chk("near_fwd_sel1", a_fwd[3:2], 1);
    id_rs[RW +: RW] = 5'd0; set_prod(0, 0, 1, 0); set_prod(1, 0, 1, 1);
    tick(); #1;
    $display("nearest: fwd_sel1=%0d", a_fwd[3:2]);
    chk("near_x0_fwd_sel1", a_fwd[3:2], 0);
    idle(); tick();

    // data-cache read miss during a flush
    branch_taken = 1'b1; tick(); branch_taken = 1'b0;
    dready_n = 1'b1; mem_rw = 2'b10; #1;
    chk("ms_stall_wb", a_swb, 1);
    chk("ms_nop_if", a_nif, 0);
    tick(); #1;
    chk("ms_state", a_state, 2);
    tick(); tick(); tick();
    dready_n = 1'b0; mem_rw = 2'b00; #1;
    chk("ms_resume_nop1", a_nif, 1);
    chk("ms_cnt_stall", a_cst, 4);
    chk("ms_cnt_stall_b", b_cst, 3);
    tick(); #1;
    chk("ms_resume_nop2", a_nif, 1);
    tick(); #1;
    $display("mem stall: cnt_stall=%0d cnt_flush=%0d nop_if=%0d", a_cst, a_cfl, a_nif);
    chk("ms_resume_done", a_nif, 0);
    chk("ms_cnt_flush", a_cfl, 7);
    dready_n = 1'b1; mem_rw = 2'b01; #1;
    chk("ms_write_no_stall", a_sif, 0);
    tick(); idle();

    // branch coincident with a load-use hazard: flush wins, no bubble
    id_rs[0 +: RW] = 5'd9; id_rs_vld[0] = 1'b1; set_prod(0, 9, 1, 1);
    branch_taken = 1'b1; #1;
    chk("br_ld_stall_id", a_sid, 0);
    chk("br_ld_nop_ex", a_nex, 1);
    tick(); branch_taken = 1'b0;
    tick(); idle(); tick(); #1;
    $display("branch+load: cnt_bubble=%0d", a_cbub);
    chk("br_ld_cnt_bubble", a_cbub, 1);

    // branch coincident with an I-cache miss: stall wins
    branch_taken = 1'b1; iready_n = 1'b1; #1;
    chk("br_ms_stall_if", a_sif, 1);
    chk("br_ms_nop_if", a_nif, 0);
    tick(); idle(); tick();

    // counter saturation on the 2-bit instance
    rst = 1'b1; tick(); rst = 1'b0;
    iready_n = 1'b1;
    repeat (6) tick();
    iready_n = 1'b0; #1;
    $display("saturation: cnt_stall_a=%0d cnt_stall_b=%0d", a_cst, b_cst);
    chk("sat_cnt_stall_a", a_cst, 6);
    chk("sat_cnt_stall_b", b_cst, 3);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
